// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the two-port master front end and downstream slaves.
// Slave select decode happens downstream, so a single psel is carried here.
interface apb_master_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant in IDLE, SETUP/ACCESS sequencing,
// per-transfer ACCESS timeout that completes the transfer with an error.
module apb_master_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  apb_master_arb_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [TW-1:0] timer;

  logic          grant1;
  logic          timed_out;
  logic [DW-1:0] done_rdata;
  logic          done_err;

  // Port 1 wins when alone, or when both ask and port 0 had the last grant.
  assign grant1    = req1_valid && (!req0_valid || !last_grant);
  assign timed_out = (TIMEOUT != 0) && (int'(timer) + 1 == TIMEOUT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    done_rdata = '0;
    done_err   = 1'b1;
    if (apb.pready) begin
      done_rdata = apb.pwrite ? '0 : apb.prdata;
      done_err   = apb.pslverr;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      timer       <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      req0_done   <= 1'b0;
      req0_rdata  <= '0;
      req0_err    <= 1'b0;
      req1_done   <= 1'b0;
      req1_rdata  <= '0;
      req1_err    <= 1'b0;
    end else begin
      // Completion outputs are single-cycle; they read as zero outside the pulse.
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner       <= grant1;
            last_grant  <= grant1;
            apb.paddr   <= grant1 ? req1_addr  : req0_addr;
            apb.pwrite  <= grant1 ? req1_write : req0_write;
            apb.pwdata  <= grant1 ? req1_wdata : req0_wdata;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            timer       <= '0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          apb.penable <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (apb.pready || timed_out) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            state       <= IDLE;
            if (owner) begin
              req1_done  <= 1'b1;
              req1_rdata <= done_rdata;
              req1_err   <= done_err;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= done_rdata;
              req0_err   <= done_err;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: latency, round-robin, wait states, timeout,
// slave error and mid-transfer reset, each with hand-computed expectations.
module tb_apb_master_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        req0_done;
  logic [31:0] req0_rdata;
  logic        req0_err;
  logic        req1_valid, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        req1_done;
  logic [31:0] req1_rdata;
  logic        req1_err;

  int errors = 0;
  int checks = 0;

  apb_master_arb_if #(.AW(32), .DW(32)) apb ();

  apb_master_arb #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req0_err   (req0_err),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .req1_err   (req1_err),
    .apb        (apb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b exp 000", {apb.psel, apb.penable, apb.pwrite}); end
    checks++; if (apb.paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h exp 0", apb.paddr); end
    checks++; if (apb.pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata: got %h exp 0", apb.pwdata); end
    checks++; if ({req0_done, req0_err, req1_done, req1_err} !== 4'b0000) begin errors++; $display("FAIL reset_done_err: got %b exp 0000", {req0_done, req0_err, req1_done, req1_err}); end
    checks++; if ({req0_rdata, req1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", {req0_rdata, req1_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    req0_write = 1'b0; req0_addr = 32'h1000_0004;
    apb.pready = 1'b1; apb.prdata = 32'h0000_00A5; apb.pslverr = 1'b0;
    req0_valid = 1'b1;
    tick(); // SETUP
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b100) begin errors++; $display("FAIL t1_setup: got %b exp 100", {apb.psel, apb.penable, apb.pwrite}); end
    checks++; if (apb.paddr !== 32'h1000_0004) begin errors++; $display("FAIL t1_paddr: got %h exp 10000004", apb.paddr); end
    tick(); // ACCESS
    checks++; if ({apb.psel, apb.penable, req0_done} !== 3'b110) begin errors++; $display("FAIL t1_access: got %b exp 110", {apb.psel, apb.penable, req0_done}); end
    tick(); // done
    checks++; if ({req0_done, req0_err, req1_done} !== 3'b100) begin errors++; $display("FAIL t1_done: got %b exp 100", {req0_done, req0_err, req1_done}); end
    checks++; if (req0_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL t1_rdata: got %h exp 000000a5", req0_rdata); end
    checks++; if (apb.psel !== 1'b0) begin errors++; $display("FAIL t1_psel_drop: got %b exp 0", apb.psel); end
    req0_valid = 1'b0;
    tick();
    checks++; if ({apb.psel, req0_done, req0_rdata} !== 34'h0) begin errors++; $display("FAIL t1_after: got %h exp 0", {apb.psel, req0_done, req0_rdata}); end
  endtask

  task automatic test_round_robin();
    logic exp_port;
    do_reset();
    req0_write = 1'b0; req0_addr = 32'h0000_0100;
    req1_write = 1'b0; req1_addr = 32'h0000_0200;
    apb.pready = 1'b1; apb.prdata = 32'h11;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_port = n[0];
      tick(); // SETUP
      checks++; if (apb.paddr !== (exp_port ? 32'h0000_0200 : 32'h0000_0100)) begin errors++; $display("FAIL t2_grant%0d_paddr: got %h exp port %0d", n, apb.paddr, exp_port); end
      tick();
      tick(); // done, bus is IDLE and both valids are still high
      checks++; if ({req1_done, req0_done} !== (exp_port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL t2_grant%0d_done: got %b exp port %0d", n, {req1_done, req0_done}, exp_port); end
      if (n == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    tick();
    checks++; if ({apb.psel, req0_done, req1_done} !== 3'b000) begin errors++; $display("FAIL t2_idle: got %b exp 000", {apb.psel, req0_done, req1_done}); end
  endtask

  task automatic test_wait_states();
    req1_write = 1'b1; req1_addr = 32'h1000_0000; req1_wdata = 32'h55;
    apb.pready = 1'b0; apb.prdata = 32'h99;
    req1_valid = 1'b1;
    tick(); // SETUP
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b101) begin errors++; $display("FAIL t3_setup: got %b exp 101", {apb.psel, apb.penable, apb.pwrite}); end
    req1_addr = 32'hFFFF_FFFF; req1_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick(); // ACCESS cycle i+1
      checks++; if ({apb.psel, apb.penable, req1_done} !== 3'b110) begin errors++; $display("FAIL t3_access%0d: got %b exp 110", i, {apb.psel, apb.penable, req1_done}); end
      checks++; if ({apb.paddr, apb.pwdata} !== {32'h1000_0000, 32'h55}) begin errors++; $display("FAIL t3_stable%0d: got %h exp 1000000000000055", i, {apb.paddr, apb.pwdata}); end
      if (i == 3) apb.pready = 1'b1;
    end
    tick();
    checks++; if ({req1_done, req1_err, req0_done, apb.penable} !== 4'b1000) begin errors++; $display("FAIL t3_done: got %b exp 1000", {req1_done, req1_err, req0_done, apb.penable}); end
    checks++; if (req1_rdata !== 32'h0) begin errors++; $display("FAIL t3_rdata_write: got %h exp 0", req1_rdata); end
    req1_valid = 1'b0; req1_write = 1'b0;
  endtask

  task automatic test_timeout();
    req0_write = 1'b0; req0_addr = 32'h1000_0008;
    apb.pready = 1'b0; apb.prdata = 32'hDEAD;
    req0_valid = 1'b1;
    tick(); // SETUP
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({apb.psel, apb.penable, req0_done} !== 3'b110) begin errors++; $display("FAIL t4_access%0d: got %b exp 110", i, {apb.psel, apb.penable, req0_done}); end
    end
    tick();
    checks++; if ({req0_done, req0_err, apb.psel, apb.penable} !== 4'b1100) begin errors++; $display("FAIL t4_timeout: got %b exp 1100", {req0_done, req0_err, apb.psel, apb.penable}); end
    checks++; if (req0_rdata !== 32'h0) begin errors++; $display("FAIL t4_rdata: got %h exp 0", req0_rdata); end
    req0_valid = 1'b0;
    tick();
    apb.pready = 1'b1; apb.prdata = 32'h77;
    req0_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++; if ({req0_done, req0_err} !== 2'b10) begin errors++; $display("FAIL t4_next_done: got %b exp 10", {req0_done, req0_err}); end
    checks++; if (req0_rdata !== 32'h77) begin errors++; $display("FAIL t4_next_rdata: got %h exp 77", req0_rdata); end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    req1_write = 1'b0; req1_addr = 32'h1000_000C;
    apb.pready = 1'b1; apb.prdata = 32'h3C; apb.pslverr = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++; if ({req1_done, req1_err, req0_done} !== 3'b110) begin errors++; $display("FAIL t5_done_err: got %b exp 110", {req1_done, req1_err, req0_done}); end
    checks++; if (req1_rdata !== 32'h3C) begin errors++; $display("FAIL t5_rdata: got %h exp 3c", req1_rdata); end
    req1_valid = 1'b0; apb.pslverr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    req0_write = 1'b0; req0_addr = 32'h1000_0004;
    apb.pready = 1'b0;
    req0_valid = 1'b1;
    tick(); // SETUP
    tick(); // ACCESS
    checks++; if ({apb.psel, apb.penable} !== 2'b11) begin errors++; $display("FAIL t6_access: got %b exp 11", {apb.psel, apb.penable}); end
    rst = 1'b1;
    tick();
    checks++; if ({apb.psel, apb.penable, req0_done, req1_done} !== 4'b0000) begin errors++; $display("FAIL t6_abort: got %b exp 0000", {apb.psel, apb.penable, req0_done, req1_done}); end
    rst = 1'b0;
    req0_addr = 32'h1000_0010; req1_addr = 32'h1000_0020; req1_write = 1'b0;
    req1_valid = 1'b1;
    tick(); // SETUP of the first post-reset grant
    checks++; if (apb.paddr !== 32'h1000_0010) begin errors++; $display("FAIL t6_grant0: got %h exp 10000010", apb.paddr); end
    checks++; if ({req0_done, req1_done} !== 2'b00) begin errors++; $display("FAIL t6_no_pulse: got %b exp 00", {req0_done, req1_done}); end
    apb.pready = 1'b1; apb.prdata = 32'h5A;
    tick();
    tick();
    checks++; if ({req0_done, req1_done, req0_err} !== 3'b100) begin errors++; $display("FAIL t6_done: got %b exp 100", {req0_done, req1_done, req0_err}); end
    checks++; if (req0_rdata !== 32'h5A) begin errors++; $display("FAIL t6_rdata: got %h exp 5a", req0_rdata); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (apb.psel !== 1'b0) begin errors++; $display("FAIL t6_idle: got %b exp 0", apb.psel); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    apb.prdata = '0; apb.pready = 1'b1; apb.pslverr = 1'b0;

    test_reset();
    test_read_latency();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_mid_transfer();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
